tsc_readout_ctrl: RTL and testbench
===================================

# tsc_readout_ctrl

Readout sequencer for the timestamp-capture ring buffer. On a dump request it snapshots the buffer's oldest-entry pointer and fill count, then reads entries oldest-first through the buffer's synchronous read port. Each 32-bit entry is serialized MSB-byte-first onto a byte-wide request/acknowledge transmit channel. It sits between the ring-buffer storage and the host-side byte link, and owns the buffer read port for the duration of a dump.

## Interface
- DEPTH, 8, ring-buffer entries; any value ≥2, not required to be a power of two
- ADDR_W, 3, read-address width; must satisfy 2^ADDR_W ≥ DEPTH
- DATA_W, 32, entry width; fixed at 32 (4 bytes per entry)

- clk  in  1  clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- start_dump  in  1  single-cycle dump request
- abort  in  1  terminate dump at next word boundary
- head  in  ADDR_W  index of oldest valid entry
- count  in  ADDR_W+1  valid entries, 0..DEPTH
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  DATA_W  read data, valid one cycle after rd_en
- tx_req  out  1  byte valid on tx_data
- tx_ack  in  1  receiver accepts byte
- tx_data  out  8  transmit byte
- tx_last  out  1  current byte is final byte of dump
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse at dump completion

## Operation
- States: IDLE, FETCH, LATCH, SEND, DONE.
- IDLE: on start_dump, capture ptr←head and remaining←min(count, DEPTH). Go to DONE if remaining=0, else to FETCH.
- FETCH: rd_en=1, rd_addr=ptr, for exactly one cycle; go to LATCH.
- LATCH: load shift register from rd_data, byte_idx←3, and go to SEND. Advance ptr: DEPTH-1 wraps to 0, otherwise +1. Decrement remaining.
- SEND: tx_req=1, tx_data=word[8*byte_idx+7 : 8*byte_idx].
  - A transfer occurs on any cycle with tx_req & tx_ack.
  - On a transfer with byte_idx>0: decrement byte_idx, stay in SEND.
  - On a transfer with byte_idx=0: go to DONE if remaining=0 or abort is high; otherwise go to FETCH.
- DONE: done=1 for one cycle, then IDLE.
- tx_last=1 only when in SEND, byte_idx=0 and remaining=0.
- abort is sampled only on the final-byte transfer. A word in flight always completes, so the receiver never sees a partial word.
- start_dump outside IDLE is ignored. head and count changes after the snapshot are ignored.
- busy=1 in every state except IDLE.
- Outputs are registered or decoded from registered state only; no combinational path from tx_ack to tx_req/tx_data.

## Timing
- Reset: state=IDLE. rd_en, rd_addr, tx_req, tx_data, tx_last, busy, done all 0. ptr, remaining, shift register cleared.
- A reset asserted mid-dump takes effect at the next edge: tx_req drops with no done pulse, and the buffer state is untouched.
- start_dump sampled at edge N:
  - rd_en high in cycle N+1.
  - rd_data captured at edge N+2.
  - tx_req high from cycle N+3.
- A byte that is accepted immediately holds tx_req for one cycle; tx_req stays high back-to-back across the 4 bytes of a word.
- Word-to-word gap: 2 cycles with tx_req low (FETCH and LATCH).
- Minimum dump duration for n entries with tx_ack tied high: 1 + 6n + 1 cycles from start_dump to done.
- count=0: done pulses in cycle N+1. No rd_en, no tx_req.
- tx_data and tx_last remain stable while tx_req=1 and tx_ack=0.

## Structure
- Shared package tsc_pkg holds:
  - the state enum: IDLE, FETCH, LATCH, SEND, DONE
  - TSC_DEPTH default (8) and TSC_BYTES_PER_WORD (4)
  - a pointer-increment-with-wrap function, also used by the capture side
- One sub-module: tsc_word_serializer.
  - Loads a 32-bit word and presents bytes MSB-first under req/ack.
  - Reports a last-byte flag.
- The controller FSM handles pointers, counting, abort and done.

## Test plan
- Basic dump: DEPTH=8, head=0, count=2, entries 0x11223344 and 0xAABBCCDD, tx_ack tied 1 → tx_data 11,22,33,44,AA,BB,CC,DD; tx_last only on DD; done 14 cycles after start_dump.
- Wrap: head=6, count=4 → rd_addr sequence 6,7,0,1, entries emitted in that order.
- Non-power-of-two DEPTH=9: head=8, count=2 → rd_addr 8 then 0.
- Back-pressure: tx_ack low for 3 cycles on byte 2 → tx_data and tx_req held stable; exactly 4 bytes transferred per word, no duplicates.
- Empty and ignored requests:
  - count=0 → done pulse at N+1, no tx_req.
  - start_dump during busy → no effect on the dump in progress.
- Abort and reset:
  - abort asserted during byte 1 of word 1 of a 3-entry dump → word 1 completes, done follows, word 2 is never read.
  - reset mid-SEND → all outputs 0 on the next cycle, no done pulse.

Source files
------------

// File: rtl/tsc_pkg.sv
// Shared definitions for the timestamp-capture ring buffer and its readout path.
//   tsc_state_e        : readout sequencer states
//   TSC_DEPTH          : default ring-buffer depth
//   TSC_BYTES_PER_WORD : bytes per 32-bit timestamp entry
//   tsc_ptr_inc()      : ring pointer increment with wrap at an arbitrary depth,
//                        shared by the capture (write) and readout (read) sides
package tsc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND,
    DONE
  } tsc_state_e;

  localparam int TSC_DEPTH          = 8;
  localparam int TSC_BYTES_PER_WORD = 4;

  // Depth need not be a power of two, so wrap explicitly instead of relying
  // on address overflow.
  function automatic int tsc_ptr_inc(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/tsc_word_serializer.sv
// Byte serializer for one 32-bit timestamp entry.
// Holds the word loaded by load_i and presents it MSB byte first. Each adv_i
// (a completed req/ack transfer) moves to the next lower byte; the index
// parks at byte 0 until the next load.
//   clk, reset : clock, synchronous active-high reset (clears word and index)
//   load_i     : capture word_i, select the most significant byte
//   word_i     : entry to serialize
//   adv_i      : current byte was accepted
//   byte_o     : currently selected byte
//   last_o     : the selected byte is the least significant one
module tsc_word_serializer
  import tsc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        adv_i,
  output logic [7:0]  byte_o,
  output logic        last_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (load_i) begin
      word_d = word_i;
      idx_d  = 2'(TSC_BYTES_PER_WORD - 1);
    end else if (adv_i && (idx_q != 2'd0)) begin
      idx_d = idx_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign byte_o = word_q[{idx_q, 3'b000} +: 8];
  assign last_o = (idx_q == 2'd0);

endmodule

// File: rtl/tsc_readout_ctrl.sv
// Readout sequencer for the timestamp-capture ring buffer.
// On start_dump it snapshots head/count, then reads entries oldest-first via
// the buffer's synchronous read port and streams each one MSB byte first on
// a req/ack byte channel. abort ends the dump after the word in flight.
//   clk, reset          : clock, synchronous active-high reset
//   start_dump, abort   : dump request / stop at next word boundary
//   head, count         : oldest-entry index and fill level (sampled at start)
//   rd_en, rd_addr      : buffer read strobe/address (data one cycle later)
//   rd_data             : buffer read data
//   tx_req, tx_ack      : byte handshake; tx_data byte, tx_last final byte
//   busy, done          : dump in progress / one-cycle completion pulse
module tsc_readout_ctrl
  import tsc_pkg::*;
#(
  parameter int DEPTH  = TSC_DEPTH,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_dump,
  input  logic              abort,
  input  logic [ADDR_W-1:0] head,
  input  logic [ADDR_W:0]   count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tx_req,
  input  logic              tx_ack,
  output logic [7:0]        tx_data,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  tsc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W:0]   count_sat;
  logic              ser_load;
  logic              ser_adv;
  logic              ser_last;

  // Guard against a fill count reported above the physical depth.
  assign count_sat = (count > DEPTH_C) ? DEPTH_C : count;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    ser_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_dump) begin
          ptr_d   = head;
          rem_d   = count_sat;
          state_d = (count_sat == '0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        // rd_data is valid this cycle; remaining counts words not yet loaded.
        ser_load = 1'b1;
        ptr_d    = ADDR_W'(tsc_ptr_inc(int'(ptr_q), DEPTH));
        rem_d    = rem_q - REM_ONE;
        state_d  = SEND;
      end
      SEND: begin
        // abort only matters on the final byte so words are never split.
        if (tx_ack && ser_last) begin
          state_d = ((rem_q == '0) || abort) ? DONE : FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  assign ser_adv = tx_req & tx_ack;

  tsc_word_serializer u_ser (
    .clk    (clk),
    .reset  (reset),
    .load_i (ser_load),
    .word_i (rd_data),
    .adv_i  (ser_adv),
    .byte_o (tx_data),
    .last_o (ser_last)
  );

  // All outputs decode registered state only; tx_ack never reaches them
  // combinationally.
  assign rd_en   = (state_q == FETCH);
  assign rd_addr = rd_en ? ptr_q : '0;
  assign tx_req  = (state_q == SEND);
  assign tx_last = tx_req & ser_last & (rem_q == '0);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_tsc_readout_ctrl.sv
// Bench for tsc_readout_ctrl: DEPTH=8 instance plus a DEPTH=9 instance for
// non-power-of-two wrap. Each instance has a behavioural ring-buffer with a
// one-cycle read latency; expected byte streams are computed from head/count
// and buffer contents with modular arithmetic.
module tb_tsc_readout_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start_dump, abort, tx_ack;
  logic [2:0]  head;
  logic [3:0]  count;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_last, busy, done;

  logic        b_start, b_abort, b_tx_ack;
  logic [3:0]  b_head;
  logic [4:0]  b_count;
  logic        b_rd_en;
  logic [3:0]  b_rd_addr;
  logic [31:0] b_rd_data;
  logic        b_tx_req;
  logic [7:0]  b_tx_data;
  logic        b_tx_last, b_busy, b_done;

  logic [31:0] mem8 [8];
  logic [31:0] mem9 [9];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, d0 = 0;
  int req_cnt = 0, b_done_cnt = 0, ack_mode = 0;

  logic [7:0] got_bytes[$], exp_bytes[$], b_bytes[$];
  bit         got_last[$], exp_last[$];
  int         got_addr[$], exp_addr[$], b_addr[$];

  tsc_readout_ctrl #(.DEPTH(8), .ADDR_W(3), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start_dump(start_dump), .abort(abort),
    .head(head), .count(count), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .tx_req(tx_req), .tx_ack(tx_ack), .tx_data(tx_data),
    .tx_last(tx_last), .busy(busy), .done(done)
  );

  tsc_readout_ctrl #(.DEPTH(9), .ADDR_W(4), .DATA_W(32)) dut9 (
    .clk(clk), .reset(reset), .start_dump(b_start), .abort(b_abort),
    .head(b_head), .count(b_count), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .tx_req(b_tx_req), .tx_ack(b_tx_ack), .tx_data(b_tx_data),
    .tx_last(b_tx_last), .busy(b_busy), .done(b_done)
  );

  // Ring-buffer storage with synchronous read
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem8[rd_addr];
    if (b_rd_en) b_rd_data <= mem9[b_rd_addr];
  end

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (ack_mode == 0) tx_ack = 1'b1;
    else if (ack_mode == 1) tx_ack = 1'($urandom_range(0, 1));
  end

  // Transaction recorder, mid-cycle
  always @(negedge clk) begin
    if (tx_req && tx_ack) begin
      got_bytes.push_back(tx_data);
      got_last.push_back(tx_last);
    end
    if (tx_req) req_cnt++;
    if (rd_en) got_addr.push_back(int'(rd_addr));
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (b_tx_req && b_tx_ack) b_bytes.push_back(b_tx_data);
    if (b_rd_en) b_addr.push_back(int'(b_rd_addr));
    if (b_done) b_done_cnt++;
  end

  // Reference: entries oldest-first from head modulo 8, MSB byte first;
  // at most nw words are sent, tx_last only on the final byte of the full dump.
  task automatic build_expect(input int h, input int c, input int nw);
    int n, a;
    exp_bytes.delete(); exp_last.delete(); exp_addr.delete();
    n = (c < nw) ? c : nw;
    for (int i = 0; i < n; i++) begin
      a = (h + i) % 8;
      exp_addr.push_back(a);
      for (int b = 3; b >= 0; b--) begin
        exp_bytes.push_back(8'(mem8[a] >> (8 * b)));
        exp_last.push_back((i == c - 1) && (b == 0));
      end
    end
  endtask

  task automatic launch(input int h, input int c);
    @(posedge clk); #1;
    got_bytes.delete(); got_last.delete(); got_addr.delete();
    req_cnt = 0;
    d0 = done_cnt;
    head = 3'(h);
    count = 4'(c);
    start_dump = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start_dump = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({rd_en, rd_addr, tx_req, tx_data, tx_last, busy, done} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {rd_en, rd_addr, tx_req, tx_data, tx_last, busy, done});
    end
    n_checks++;
    if ({b_rd_en, b_tx_req, b_tx_last, b_busy, b_done} !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_outputs9: got %b expected 0", {b_rd_en, b_tx_req, b_tx_last, b_busy, b_done});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || tx_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b tx_req=%b expected 0 0", busy, tx_req);
    end
  endtask

  task automatic test_basic();
    bit ok;
    ack_mode = 0;
    mem8[0] = 32'h11223344;
    mem8[1] = 32'hAABBCCDD;
    build_expect(0, 2, 8);
    launch(0, 2);
    wait_done(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_done: got no done expected done"); end
    n_checks++;
    if (done_cyc - start_cyc + 1 != 14) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d cycles expected 14", done_cyc - start_cyc + 1);
    end
    n_checks++;
    if (req_cnt != 8) begin n_fail++; $display("FAIL basic_req_cycles: got %0d expected 8", req_cnt); end
    n_checks++;
    if (got_bytes.size() != exp_bytes.size()) begin
      n_fail++;
      $display("FAIL basic_nbytes: got %0d expected %0d", got_bytes.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i] || got_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL basic_byte%0d: got %h last=%0b expected %h last=%0b", i, got_bytes[i], got_last[i], exp_bytes[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    ack_mode = 0;
    foreach (mem8[i]) mem8[i] = $urandom;
    build_expect(6, 4, 8);
    launch(6, 4);
    wait_done(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wrap_done: got no done expected done"); end
    n_checks++;
    if (got_addr.size() != 4) begin n_fail++; $display("FAIL wrap_nreads: got %0d expected 4", got_addr.size()); end
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] != exp_addr[i]) begin
        n_fail++;
        $display("FAIL wrap_addr%0d: got %0d expected %0d", i, got_addr[i], exp_addr[i]);
      end
    end
    n_checks++;
    if (got_bytes.size() != exp_bytes.size()) begin
      n_fail++;
      $display("FAIL wrap_nbytes: got %0d expected %0d", got_bytes.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i] || got_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL wrap_byte%0d: got %h last=%0b expected %h last=%0b", i, got_bytes[i], got_last[i], exp_bytes[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_depth9();
    bit ok;
    int bd0;
    int ea[2];
    logic [7:0] eb[$];
    foreach (mem9[i]) mem9[i] = $urandom;
    ea[0] = 8;
    ea[1] = 0;
    for (int w = 0; w < 2; w++)
      for (int b = 3; b >= 0; b--) eb.push_back(8'(mem9[ea[w]] >> (8 * b)));
    @(posedge clk); #1;
    b_bytes.delete(); b_addr.delete();
    bd0 = b_done_cnt;
    b_head = 4'd8;
    b_count = 5'd2;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (b_done_cnt != bd0) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL d9_done: got no done expected done"); end
    n_checks++;
    if (b_addr.size() != 2) begin n_fail++; $display("FAIL d9_nreads: got %0d expected 2", b_addr.size()); end
    for (int i = 0; i < 2 && i < b_addr.size(); i++) begin
      n_checks++;
      if (b_addr[i] != ea[i]) begin n_fail++; $display("FAIL d9_addr%0d: got %0d expected %0d", i, b_addr[i], ea[i]); end
    end
    n_checks++;
    if (b_bytes.size() != 8) begin n_fail++; $display("FAIL d9_nbytes: got %0d expected 8", b_bytes.size()); end
    for (int i = 0; i < 8 && i < b_bytes.size(); i++) begin
      n_checks++;
      if (b_bytes[i] !== eb[i]) begin n_fail++; $display("FAIL d9_byte%0d: got %h expected %h", i, b_bytes[i], eb[i]); end
    end
  endtask

  task automatic test_backpressure();
    int h, stall;
    bit ok;
    ack_mode = 2;
    tx_ack = 1'b1;
    foreach (mem8[i]) mem8[i] = $urandom;
    h = $urandom_range(0, 7);
    build_expect(h, 2, 8);
    launch(h, 2);
    stall = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      tx_ack = !(got_bytes.size() == 1 && stall < 3);
      @(negedge clk);
      if (!tx_ack) begin
        stall++;
        n_checks++;
        if (tx_req !== 1'b1 || tx_data !== exp_bytes[1] || tx_last !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_hold%0d: got req=%b data=%h last=%b expected 1 %h 0", stall, tx_req, tx_data, tx_last, exp_bytes[1]);
        end
      end
      if (done_cnt != d0) break;
    end
    @(negedge clk); #1;
    ok = (done_cnt != d0);
    tx_ack = 1'b1;
    ack_mode = 0;
    n_checks++;
    if (!ok || stall != 3) begin n_fail++; $display("FAIL bp_done: got done=%0b stalls=%0d expected 1 3", ok, stall); end
    n_checks++;
    if (got_bytes.size() != 8) begin n_fail++; $display("FAIL bp_nbytes: got %0d expected 8", got_bytes.size()); end
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i] || got_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL bp_byte%0d: got %h last=%0b expected %h last=%0b", i, got_bytes[i], got_last[i], exp_bytes[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_empty();
    bit ok;
    ack_mode = 0;
    launch($urandom_range(0, 7), 0);
    wait_done(20, ok);
    n_checks++;
    if (!ok || done_cyc - start_cyc != 1) begin
      n_fail++;
      $display("FAIL empty_done: got done=%0b at +%0d expected 1 at +1", ok, done_cyc - start_cyc);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (req_cnt != 0 || got_addr.size() != 0) begin
      n_fail++;
      $display("FAIL empty_activity: got req=%0d reads=%0d expected 0 0", req_cnt, got_addr.size());
    end
  endtask

  task automatic test_ignored_start();
    int h;
    bit ok;
    ack_mode = 0;
    foreach (mem8[i]) mem8[i] = $urandom;
    h = $urandom_range(0, 7);
    build_expect(h, 2, 8);
    launch(h, 2);
    repeat (3) @(posedge clk);
    #1;
    head = 3'(h + 3);
    count = 4'd5;
    start_dump = 1'b1;
    @(posedge clk); #1;
    start_dump = 1'b0;
    wait_done(100, ok);
    repeat (12) @(negedge clk);
    n_checks++;
    if (!ok || done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL ign_done: got %0d done pulses expected 1", done_cnt - d0);
    end
    n_checks++;
    if (got_addr.size() != 2) begin n_fail++; $display("FAIL ign_nreads: got %0d expected 2", got_addr.size()); end
    n_checks++;
    if (got_bytes.size() != exp_bytes.size()) begin
      n_fail++;
      $display("FAIL ign_nbytes: got %0d expected %0d", got_bytes.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i]) begin
        n_fail++;
        $display("FAIL ign_byte%0d: got %h expected %h", i, got_bytes[i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_abort();
    int h;
    bit ok;
    ack_mode = 0;
    foreach (mem8[i]) mem8[i] = $urandom;
    h = $urandom_range(0, 7);
    build_expect(h, 3, 1);
    launch(h, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_req) break;
    end
    @(posedge clk); #1;
    abort = 1'b1;
    wait_done(100, ok);
    abort = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (!ok || done_cnt != d0 + 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: got pulses=%0d busy=%b expected 1 0", done_cnt - d0, busy);
    end
    n_checks++;
    if (got_addr.size() != 1) begin n_fail++; $display("FAIL abort_nreads: got %0d expected 1", got_addr.size()); end
    n_checks++;
    if (got_bytes.size() != 4) begin n_fail++; $display("FAIL abort_nbytes: got %0d expected 4", got_bytes.size()); end
    for (int i = 0; i < 4 && i < got_bytes.size(); i++) begin
      n_checks++;
      if (got_bytes[i] !== exp_bytes[i] || got_last[i] !== exp_last[i]) begin
        n_fail++;
        $display("FAIL abort_byte%0d: got %h last=%0b expected %h last=%0b", i, got_bytes[i], got_last[i], exp_bytes[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_random();
    int h, c;
    bit ok;
    ack_mode = 1;
    for (int it = 0; it < 8; it++) begin
      foreach (mem8[i]) mem8[i] = $urandom;
      h = $urandom_range(0, 7);
      c = $urandom_range(0, 8);
      build_expect(h, c, 8);
      launch(h, c);
      wait_done(500, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rand%0d_done: got no done expected done (h=%0d c=%0d)", it, h, c); end
      n_checks++;
      if (got_addr.size() != exp_addr.size() || got_bytes.size() != exp_bytes.size()) begin
        n_fail++;
        $display("FAIL rand%0d_sizes: got reads=%0d bytes=%0d expected %0d %0d", it, got_addr.size(), got_bytes.size(), exp_addr.size(), exp_bytes.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        n_checks++;
        if (got_addr[i] != exp_addr[i]) begin
          n_fail++;
          $display("FAIL rand%0d_addr%0d: got %0d expected %0d", it, i, got_addr[i], exp_addr[i]);
        end
      end
      for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++) begin
        n_checks++;
        if (got_bytes[i] !== exp_bytes[i] || got_last[i] !== exp_last[i]) begin
          n_fail++;
          $display("FAIL rand%0d_byte%0d: got %h last=%0b expected %h last=%0b", it, i, got_bytes[i], got_last[i], exp_bytes[i], exp_last[i]);
        end
      end
    end
    ack_mode = 0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    ack_mode = 0;
    foreach (mem8[i]) mem8[i] = $urandom;
    launch($urandom_range(0, 7), 3);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (got_bytes.size() >= 2) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rmid_progress: got %0d bytes expected >=2", got_bytes.size()); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({rd_en, rd_addr, tx_req, tx_data, tx_last, busy, done} !== 16'h0) begin
      n_fail++;
      $display("FAIL rmid_outputs: got %h expected 0", {rd_en, rd_addr, tx_req, tx_data, tx_last, busy, done});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_no_done: got pulses=%0d busy=%b expected 0 0", done_cnt - d0, busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_dump = 1'b0;
    abort = 1'b0;
    tx_ack = 1'b1;
    head = '0;
    count = '0;
    b_start = 1'b0;
    b_abort = 1'b0;
    b_tx_ack = 1'b1;
    b_head = '0;
    b_count = '0;
    foreach (mem8[i]) mem8[i] = '0;
    foreach (mem9[i]) mem9[i] = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_depth9();
    test_backpressure();
    test_empty();
    test_ignored_start();
    test_abort();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
